pipe_skid_stage: RTL and testbench

Parametrised inter-stage pipeline register with a valid/ready handshake and a two-entry skid buffer, replacing fixed per-stage latches with write-enable. One instance sits between each pair of CPU stages (F/D, D/E, E/M, M/W). It carries an arbitrary-width bundle (instruction, PC, control), flushes to a NOP bubble, and counts stall cycles for performance debug.

---
 rtl/pipe_skid_stage.sv | 143 ++++++++++++++
 tb/tb_pipe_skid_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - Inter-stage pipeline register with valid/ready handshake and two-entry skid buffer
`timescale 1ns/1ps

module pipe_skid_stage #(
    parameter int unsigned       DATA_W     = 64,
    parameter logic [DATA_W-1:0] RESET_DATA = '0,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        count,
    output logic [CNT_W-1:0]  stall_cycles,
    input  logic              clr_stats
);

    // Occupancy states: main entry drives the outputs, skid entry absorbs one
    // extra bundle while in_ready (registered) catches up with back-pressure.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [1:0]        count_q, count_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic accept;
    logic drain;
    logic stall_now;
    logic stall_sat;

    // Handshake qualifiers are built only from registered outputs, so there is
    // no combinational path from out_ready to in_ready.
    assign accept    = in_valid & in_ready_q;
    assign drain     = out_valid_q & out_ready;
    assign stall_now = out_valid_q & ~out_ready;
    assign stall_sat = &stall_q;

    // Next occupancy state and entry contents; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = RESET_DATA;
            skid_d  = RESET_DATA;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                        main_d  = RESET_DATA;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = RESET_DATA;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = RESET_DATA;
                    skid_d  = RESET_DATA;
                end
            endcase
        end
    end

    // Registered outputs are derived from the next state so they line up with it.
    always_comb begin
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
        case (state_d)
            ST_ONE:  count_d = 2'd1;
            ST_FULL: count_d = 2'd2;
            default: count_d = 2'd0;
        endcase
    end

    // Saturating stall counter; clear beats increment, flush leaves it alone.
    always_comb begin
        stall_d = stall_q;
        if (clr_stats) begin
            stall_d = '0;
        end else if (stall_now && !stall_sat) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // State and output registers, asynchronously forced to the bubble on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= RESET_DATA;
            skid_q      <= RESET_DATA;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            count_q     <= 2'd0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
            stall_q     <= stall_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = main_q;
    assign count        = count_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - Self-checking bench for pipe_skid_stage against a queue model
`timescale 1ns/1ps

module tb_pipe_skid_stage;

    localparam logic [63:0] RD = 64'h0000_0000_0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic        clr_stats = 1'b0;
    logic [63:0] in_data = '0;

    logic        in_ready, out_valid;
    logic [63:0] out_data;
    logic [1:0]  count;
    logic [15:0] stall16;

    logic        in_ready4, out_valid4;
    logic [63:0] out_data4;
    logic [1:0]  count4;
    logic [3:0]  stall4;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: a FIFO of at most two bundles plus a registered ready.
    logic [63:0] mq[$];
    bit          m_ready = 1'b1;
    int unsigned m_stall = 0;
    bit          m_acc, m_drn;
    logic [63:0] m_junk;

    pipe_skid_stage #(.DATA_W(64), .RESET_DATA(RD), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .flush(flush), .count(count),
        .stall_cycles(stall16), .clr_stats(clr_stats)
    );

    pipe_skid_stage #(.DATA_W(64), .RESET_DATA(RD), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .flush(flush), .count(count4),
        .stall_cycles(stall4), .clr_stats(clr_stats)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Model update on each active edge, from the inputs held since the last negedge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_ready = 1'b1;
            m_stall = 0;
        end else begin
            m_acc = in_valid && m_ready;
            m_drn = (mq.size() > 0) && out_ready;
            if (clr_stats) m_stall = 0;
            else if ((mq.size() > 0) && !out_ready) m_stall++;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_drn) m_junk = mq.pop_front();
                if (m_acc) mq.push_back(in_data);
            end
            m_ready = (mq.size() < 2);
        end
    end

    // Compare every cycle away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
            check("out_data", out_data, (mq.size() > 0) ? mq[0] : RD);
            check("count", 64'(count), 64'(mq.size()));
            check("in_ready", 64'(in_ready), 64'(m_ready));
            check("stall16", 64'(stall16), 64'((m_stall > 65535) ? 65535 : m_stall));
            check("stall4", 64'(stall4), 64'((m_stall > 15) ? 15 : m_stall));
            check("out_data4", out_data4, (mq.size() > 0) ? mq[0] : RD);
        end
    end

    initial begin
        // Reset values
        repeat (3) tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_data", out_data, RD);
        check("rst_stall", 64'(stall16), 64'd0);
        reset = 1'b1;

        // Streaming 1..8 with out_ready high
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            tick();
            check("stream_data", out_data, 64'(i));
            check("stream_count", 64'(count), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_empty", 64'(count), 64'd0);
        check("stream_stall", 64'(stall16), 64'd0);

        // Back-pressure: A, B held, C refused, then released in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        tick();
        check("bp_A_data", out_data, 64'hA);
        check("bp_A_ready", 64'(in_ready), 64'd1);
        in_data = 64'hB;
        tick();
        check("bp_B_count", 64'(count), 64'd2);
        check("bp_B_ready", 64'(in_ready), 64'd0);
        in_data = 64'hC;
        repeat (3) tick();
        check("bp_C_count", 64'(count), 64'd2);
        check("bp_C_head", out_data, 64'hA);
        out_ready = 1'b1;
        tick();
        check("bp_rel_B", out_data, 64'hB);
        check("bp_rel_ready", 64'(in_ready), 64'd1);
        check("bp_stall", 64'(stall16), 64'd4);
        tick();
        check("bp_rel_C", out_data, 64'hC);
        in_valid = 1'b0;
        tick();
        check("bp_drained", 64'(out_valid), 64'd0);

        // Flush while full with a concurrent accept of D
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hE;
        tick();
        in_data = 64'hF;
        tick();
        check("fl_full", 64'(count), 64'd2);
        in_data = 64'hD;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_count", 64'(count), 64'd0);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_data", out_data, RD);
        out_ready = 1'b1;
        repeat (2) tick();
        check("fl_noD", 64'(out_valid), 64'd0);

        // Stall counter saturation on the narrow instance, then clear under stall
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h55;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        check("cnt_sat4", 64'(stall4), 64'd15);
        check("cnt_20", 64'(stall16), 64'd20);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("cnt_clr4", 64'(stall4), 64'd0);
        check("cnt_clr16", 64'(stall16), 64'd0);

        // Asynchronous reset mid-stream with two held bundles
        in_valid = 1'b1;
        in_data  = 64'h77;
        tick();
        in_valid = 1'b0;
        check("ar_full", 64'(count), 64'd2);
        #2 reset = 1'b0;
        #1;
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_in_ready", 64'(in_ready), 64'd1);
        check("ar_count", 64'(count), 64'd0);
        check("ar_out_data", out_data, RD);
        check("ar_stall", 64'(stall16), 64'd0);
        tick();
        reset = 1'b1;

        // Randomized traffic checked by the model every cycle
        for (int seg = 0; seg < 6; seg++) begin
            int unsigned bias;
            bias = $urandom_range(1, 7);
            for (int c = 0; c < 500; c++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = {$urandom, $urandom};
                out_ready = ($urandom_range(0, 7) < bias);
                flush     = ($urandom_range(0, 31) == 0);
                clr_stats = ($urandom_range(0, 63) == 0);
                tick();
            end
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        clr_stats = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
